// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage CPU (F0, F1, R, X, W).
// Owns the PC, the per-stage valid bits and the per-stage writer tags. It detects
// read-after-write hazards at decode (replay), applies jump redirects from X and
// sequences halt through a one-cycle drain into a terminal halted state.
module pipe_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] pc,
    output logic [15:0] f0_pc,
    output logic [15:0] f1_pc,
    output logic        f0_valid,
    output logic        f1_valid,
    output logic        r_valid,
    output logic        x_valid,
    output logic        w_valid,
    output logic        r_load,
    input  logic [3:0]  d_src0,
    input  logic [3:0]  d_src1,
    input  logic        d_use0,
    input  logic        d_use1,
    input  logic        d_wen,
    input  logic [3:0]  d_waddr,
    input  logic        x_taken,
    input  logic [15:0] x_target,
    input  logic        x_halt,
    output logic        halted,
    output logic [15:0] retire_count
);

    localparam logic [1:0] StRun    = 2'd0;
    localparam logic [1:0] StDrain  = 2'd1;
    localparam logic [1:0] StHalted = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] f0_pc_q, f0_pc_d;
    logic [15:0] f1_pc_q, f1_pc_d;
    logic        f0_valid_q, f0_valid_d;
    logic        f1_valid_q, f1_valid_d;
    logic        r_valid_q, r_valid_d;
    logic        x_valid_q, x_valid_d;
    logic        w_valid_q, w_valid_d;
    logic        r_wen_q, r_wen_d;
    logic [3:0]  r_waddr_q, r_waddr_d;
    logic        x_wen_q, x_wen_d;
    logic [3:0]  x_waddr_q, x_waddr_d;
    logic        w_wen_q, w_wen_d;
    logic [3:0]  w_waddr_q, w_waddr_d;
    logic [15:0] retire_q, retire_d;

    logic run;
    logic halt_ev;
    logic redirect;
    logic hazard;
    logic hit0;
    logic hit1;

    // Jump targets are word aligned; the low bit of the target is discarded.
    logic unused_target_lsb;
    assign unused_target_lsb = x_target[0];

    // A register source collides with any live writer still ahead of the register-file
    // write, including W since that write only becomes readable on the following cycle.
    function automatic logic tag_hit(
        input logic [3:0] addr,
        input logic       rv, input logic rw, input logic [3:0] ra,
        input logic       xv, input logic xw, input logic [3:0] xa,
        input logic       wv, input logic ww, input logic [3:0] wa
    );
        return (rv & rw & (ra == addr)) |
               (xv & xw & (xa == addr)) |
               (wv & ww & (wa == addr));
    endfunction

    // Event decode for the current cycle; halt outranks redirect, both outrank hazard.
    always_comb begin
        run      = (state_q == StRun);
        halt_ev  = run & x_valid_q & x_halt;
        redirect = run & x_valid_q & x_taken & ~x_halt;
        hit0     = tag_hit(d_src0,
                           r_valid_q, r_wen_q, r_waddr_q,
                           x_valid_q, x_wen_q, x_waddr_q,
                           w_valid_q, w_wen_q, w_waddr_q);
        hit1     = tag_hit(d_src1,
                           r_valid_q, r_wen_q, r_waddr_q,
                           x_valid_q, x_wen_q, x_waddr_q,
                           w_valid_q, w_wen_q, w_waddr_q);
        // Register 0 is hardwired, so it can never be the subject of a hazard.
        hazard   = f1_valid_q &
                   ((d_use0 & (d_src0 != 4'd0) & hit0) |
                    (d_use1 & (d_src1 != 4'd0) & hit1));
        r_load   = f1_valid_q & ~hazard & ~redirect & ~halt_ev & run;
    end

    // Control FSM: RUN until a halt reaches X, one drain cycle, then halted for good.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (halt_ev) state_d = StDrain;
            StDrain:  state_d = StHalted;
            StHalted: state_d = StHalted;
            default:  state_d = StHalted;
        endcase
    end

    // Fetch address and the PCs travelling with F0/F1.
    always_comb begin
        pc_d    = pc_q;
        f0_pc_d = f0_pc_q;
        f1_pc_d = f1_pc_q;
        if (run && !halt_ev) begin
            f0_pc_d = pc_q;
            f1_pc_d = f0_pc_q;
            if (redirect) begin
                pc_d = {x_target[15:1], 1'b0};
            end else if (hazard) begin
                // Refetch the stalled instruction from F1.
                pc_d = f1_pc_q;
            end else begin
                pc_d = pc_q + 16'd2;
            end
        end
    end

    // Stage valid bits; everything outside RUN (and on the halt edge) goes empty.
    always_comb begin
        f0_valid_d = 1'b0;
        f1_valid_d = 1'b0;
        r_valid_d  = 1'b0;
        x_valid_d  = 1'b0;
        w_valid_d  = 1'b0;
        if (run && !halt_ev) begin
            // r_load already folds in hazard and redirect squashing of F1.
            r_valid_d = r_load;
            x_valid_d = r_valid_q;
            w_valid_d = x_valid_q;
            if (!redirect && !hazard) begin
                f0_valid_d = 1'b1;
                f1_valid_d = f0_valid_q;
            end
        end
    end

    // Writer tags shadow the valid bits; a bubble entering R carries wen=0.
    always_comb begin
        r_wen_d   = 1'b0;
        r_waddr_d = 4'd0;
        x_wen_d   = 1'b0;
        x_waddr_d = 4'd0;
        w_wen_d   = 1'b0;
        w_waddr_d = 4'd0;
        if (run && !halt_ev) begin
            r_wen_d   = d_wen & r_load;
            r_waddr_d = d_waddr;
            x_wen_d   = r_wen_q;
            x_waddr_d = r_waddr_q;
            w_wen_d   = x_wen_q;
            w_waddr_d = x_waddr_q;
        end
    end

    // Retirement counter; wraps naturally at 16 bits.
    always_comb begin
        retire_d = retire_q;
        if (w_valid_q) begin
            retire_d = retire_q + 16'd1;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            pc_q       <= RESET_PC;
            f0_pc_q    <= 16'd0;
            f1_pc_q    <= 16'd0;
            f0_valid_q <= 1'b0;
            f1_valid_q <= 1'b0;
            r_valid_q  <= 1'b0;
            x_valid_q  <= 1'b0;
            w_valid_q  <= 1'b0;
            r_wen_q    <= 1'b0;
            r_waddr_q  <= 4'd0;
            x_wen_q    <= 1'b0;
            x_waddr_q  <= 4'd0;
            w_wen_q    <= 1'b0;
            w_waddr_q  <= 4'd0;
            retire_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            f0_pc_q    <= f0_pc_d;
            f1_pc_q    <= f1_pc_d;
            f0_valid_q <= f0_valid_d;
            f1_valid_q <= f1_valid_d;
            r_valid_q  <= r_valid_d;
            x_valid_q  <= x_valid_d;
            w_valid_q  <= w_valid_d;
            r_wen_q    <= r_wen_d;
            r_waddr_q  <= r_waddr_d;
            x_wen_q    <= x_wen_d;
            x_waddr_q  <= x_waddr_d;
            w_wen_q    <= w_wen_d;
            w_waddr_q  <= w_waddr_d;
            retire_q   <= retire_d;
        end
    end

    assign pc           = pc_q;
    assign f0_pc        = f0_pc_q;
    assign f1_pc        = f1_pc_q;
    assign f0_valid     = f0_valid_q;
    assign f1_valid     = f1_valid_q;
    assign r_valid      = r_valid_q;
    assign x_valid      = x_valid_q;
    assign w_valid      = w_valid_q;
    assign halted       = (state_q == StHalted);
    assign retire_count = retire_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: free-run, RAW replay (R and W writers), r0 exemption,
// redirect over a hazard, halt/drain/reset, and PC wrap on a second instance.
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  d_src0, d_src1, d_waddr;
    logic        d_use0, d_use1, d_wen;
    logic        x_taken, x_halt;
    logic [15:0] x_target;

    logic [15:0] pc, f0_pc, f1_pc, retire_count;
    logic        f0_valid, f1_valid, r_valid, x_valid, w_valid, r_load, halted;

    // Second instance exercising the PC wrap; decode/execute inputs held quiet.
    logic [3:0]  q_src0, q_src1, q_waddr;
    logic        q_use0, q_use1, q_wen, q_taken, q_halt;
    logic [15:0] q_target;
    logic [15:0] wr_pc, wr_f0_pc, wr_f1_pc, wr_retire;
    logic        wr_f0v, wr_f1v, wr_rv, wr_xv, wr_wv, wr_rload, wr_halted;

    int n_checks;
    int n_errors;

    pipe_ctrl #(.RESET_PC(16'h0000)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .f0_pc        (f0_pc),
        .f1_pc        (f1_pc),
        .f0_valid     (f0_valid),
        .f1_valid     (f1_valid),
        .r_valid      (r_valid),
        .x_valid      (x_valid),
        .w_valid      (w_valid),
        .r_load       (r_load),
        .d_src0       (d_src0),
        .d_src1       (d_src1),
        .d_use0       (d_use0),
        .d_use1       (d_use1),
        .d_wen        (d_wen),
        .d_waddr      (d_waddr),
        .x_taken      (x_taken),
        .x_target     (x_target),
        .x_halt       (x_halt),
        .halted       (halted),
        .retire_count (retire_count)
    );

    pipe_ctrl #(.RESET_PC(16'hFFFC)) u_wrap (
        .clk          (clk),
        .reset        (reset),
        .pc           (wr_pc),
        .f0_pc        (wr_f0_pc),
        .f1_pc        (wr_f1_pc),
        .f0_valid     (wr_f0v),
        .f1_valid     (wr_f1v),
        .r_valid      (wr_rv),
        .x_valid      (wr_xv),
        .w_valid      (wr_wv),
        .r_load       (wr_rload),
        .d_src0       (q_src0),
        .d_src1       (q_src1),
        .d_use0       (q_use0),
        .d_use1       (q_use1),
        .d_wen        (q_wen),
        .d_waddr      (q_waddr),
        .x_taken      (q_taken),
        .x_target     (q_target),
        .x_halt       (q_halt),
        .halted       (wr_halted),
        .retire_count (wr_retire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_src0   = 4'd0;
        d_src1   = 4'd0;
        d_use0   = 1'b0;
        d_use1   = 1'b0;
        d_wen    = 1'b0;
        d_waddr  = 4'd0;
        x_taken  = 1'b0;
        x_halt   = 1'b0;
        x_target = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [15:0] valids();
        return 16'({f0_valid, f1_valid, r_valid, x_valid, w_valid});
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        q_src0 = 4'd0; q_src1 = 4'd0; q_waddr = 4'd0;
        q_use0 = 1'b0; q_use1 = 1'b0; q_wen = 1'b0;
        q_taken = 1'b0; q_halt = 1'b0; q_target = 16'h0000;

        // Reset and free-run
        do_reset();
        check("rst_pc", pc, 16'h0000);
        check("rst_f0_pc", f0_pc, 16'h0000);
        check("rst_f1_pc", f1_pc, 16'h0000);
        check("rst_valids", valids(), 16'h0000);
        check("rst_halted", 16'(halted), 16'd0);
        check("rst_retire", retire_count, 16'd0);
        check("wrap_rst_pc", wr_pc, 16'hFFFC);
        for (int n = 1; n <= 8; n++) begin
            tick();
            check($sformatf("run_pc_%0d", n), pc, 16'(2 * n));
            if (n == 1) begin
                check("run_f0_valid", 16'(f0_valid), 16'd1);
                check("run_f0_pc", f0_pc, 16'h0000);
                check("wrap_pc_1", wr_pc, 16'hFFFE);
            end
            if (n == 2) check("wrap_pc_2", wr_pc, 16'h0000);
            if (n == 3) check("wrap_pc_3", wr_pc, 16'h0002);
            if (n == 4) check("run_w_valid_4", 16'(w_valid), 16'd0);
            if (n == 5) check("run_w_valid_5", 16'(w_valid), 16'd1);
        end
        check("run_retire_3", retire_count, 16'd3);

        // RAW replay: writer to r3 in R, consumer in F1
        do_reset();
        tick();
        tick();
        d_wen = 1'b1; d_waddr = 4'd3;
        #1 check("raw_writer_load", 16'(r_load), 16'd1);
        tick();
        d_wen = 1'b0; d_use0 = 1'b1; d_src0 = 4'd3;
        #1 check("raw_hazard_rload", 16'(r_load), 16'd0);
        tick();
        check("raw_replay_pc", pc, 16'h0002);
        check("raw_replay_valids", valids(), 16'b00010);
        check("raw_bubble_rload", 16'(r_load), 16'd0);
        tick();
        check("raw_refetch_f0_pc", f0_pc, 16'h0002);
        check("raw_refetch_valids", valids(), 16'b10001);
        tick();
        check("raw_reenter_f1_pc", f1_pc, 16'h0002);
        check("raw_reenter_valids", valids(), 16'b11000);
        check("raw_retry_rload", 16'(r_load), 16'd1);
        check("raw_retire", retire_count, 16'd1);

        // Writer visible through X and W tags
        do_reset();
        tick();
        tick();
        d_wen = 1'b1; d_waddr = 4'd7;
        #1 check("wh_writer_load", 16'(r_load), 16'd1);
        tick();
        d_wen = 1'b0;
        #1 check("wh_nouse_load", 16'(r_load), 16'd1);
        tick();
        d_use1 = 1'b1; d_src1 = 4'd9; d_use0 = 1'b0; d_src0 = 4'd7;
        #1 check("wh_unused_src_load", 16'(r_load), 16'd1);
        tick();
        d_src1 = 4'd7;
        #1 check("wh_w_hit_rload", 16'(r_load), 16'd0);
        tick();
        check("wh_replay_pc", pc, 16'h0006);
        check("wh_replay_valids", valids(), 16'b00011);

        // r0 exemption
        do_reset();
        tick();
        tick();
        d_wen = 1'b1; d_waddr = 4'd0;
        #1 check("r0_writer_load", 16'(r_load), 16'd1);
        tick();
        d_wen = 1'b0; d_use0 = 1'b1; d_src0 = 4'd0; d_use1 = 1'b1; d_src1 = 4'd0;
        #1 check("r0_exempt_rload", 16'(r_load), 16'd1);
        tick();
        check("r0_pc", pc, 16'h0008);

        // Redirect with a hazard present
        do_reset();
        tick();
        tick();
        tick();
        d_wen = 1'b1; d_waddr = 4'd4;
        #1 check("rd_writer_load", 16'(r_load), 16'd1);
        tick();
        d_wen = 1'b0; d_use0 = 1'b1; d_src0 = 4'd4;
        x_taken = 1'b1; x_target = 16'h0021;
        #1 check("rd_rload", 16'(r_load), 16'd0);
        tick();
        idle();
        check("rd_pc", pc, 16'h0020);
        check("rd_front_valids", 16'({f0_valid, f1_valid, r_valid}), 16'd0);
        check("rd_jump_in_w", 16'(w_valid), 16'd1);
        tick();
        check("rd_retire", retire_count, 16'd1);
        check("rd_target_f0_pc", f0_pc, 16'h0020);
        check("rd_target_f0_valid", 16'(f0_valid), 16'd1);
        check("rd_pc_next", pc, 16'h0022);

        // Halt beats taken jump; drain; halted; reset recovers
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        x_halt = 1'b1; x_taken = 1'b1; x_target = 16'h0040;
        #1 check("ht_rload", 16'(r_load), 16'd0);
        tick();
        idle();
        check("ht_pc_hold", pc, 16'h000A);
        check("ht_valids", valids(), 16'd0);
        check("ht_halted_early", 16'(halted), 16'd0);
        check("ht_retire_drain", retire_count, 16'd1);
        tick();
        check("ht_halted", 16'(halted), 16'd1);
        x_taken = 1'b1; x_target = 16'h0100; d_wen = 1'b1; d_use0 = 1'b1; d_src0 = 4'd2;
        tick();
        tick();
        check("ht_pc_frozen", pc, 16'h000A);
        check("ht_valids_frozen", valids(), 16'd0);
        check("ht_retire_frozen", retire_count, 16'd1);
        check("ht_still_halted", 16'(halted), 16'd1);
        check("ht_rload_frozen", 16'(r_load), 16'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ht_reset_pc", pc, 16'h0000);
        check("ht_reset_halted", 16'(halted), 16'd0);
        check("ht_reset_retire", retire_count, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
